// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared sizing helpers and the round/saturate function
// used by the conv_mac_array datapath.
package conv_mac_pkg;

  // Working width of the round/saturate helper; must exceed any accumulator width.
  localparam int SAT_W = 128;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < value) begin
        r = k + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Full-precision width of one channel dot product.
  function automatic int psum_width(input int data_w, input int in_ch);
    return 2 * data_w + clog2(in_ch);
  endfunction

  // Accumulator width: dot products summed over all taps plus bias headroom.
  function automatic int acc_width(input int data_w, input int in_ch, input int taps);
    return psum_width(data_w, in_ch) + clog2(taps) + 1;
  endfunction

  // Round half-up, arithmetic shift by frac_bits, then clamp to a signed data_w range.
  function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                        input int frac_bits,
                                                        input int data_w);
    logic signed [SAT_W-1:0] one_s;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one_s    = '0;
    one_s[0] = 1'b1;
    r        = acc;
    if (frac_bits > 0) begin
      r = r + (one_s <<< (frac_bits - 1));
    end else begin
      r = r;
    end
    r  = r >>> frac_bits;
    hi = (one_s <<< (data_w - 1)) - one_s;
    lo = -(one_s <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_array_lane.sv
// conv_mac_lane: one output channel of conv_mac_array.
// P1 registers the IN_CH-wide dot product (and the window bias on the first
// beat); P2 accumulates over the window and, on the last beat, rounds,
// saturates and loads the output register in the same edge.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero.
module conv_mac_lane
  import conv_mac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IN_CH     = 3,
  parameter int TAPS      = 9,
  parameter int FRAC_BITS = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p1_load_i,
  input  logic                    p1_first_i,
  input  logic [IN_CH*DATA_W-1:0] pixel_i,
  input  logic [IN_CH*DATA_W-1:0] weight_i,
  input  logic [DATA_W-1:0]       bias_i,
  input  logic                    acc_en_i,
  input  logic                    acc_first_i,
  input  logic                    res_load_i,
  output logic [DATA_W-1:0]       data_o
);

  localparam int PS_W  = psum_width(DATA_W, IN_CH);
  localparam int ACC_W = acc_width(DATA_W, IN_CH, TAPS);

  logic signed [PS_W-1:0]   psum_d;
  logic signed [PS_W-1:0]   psum_q;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_base_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [DATA_W-1:0] res_sat_s;
  logic [DATA_W-1:0]        res_d;
  logic [DATA_W-1:0]        data_q;

  // Dot product of this lane's weight set with the incoming pixel vector, full precision.
  always_comb begin
    psum_d = '0;
    for (int i = 0; i < IN_CH; i++) begin
      psum_d = psum_d + PS_W'((2*DATA_W)'($signed(pixel_i[i*DATA_W +: DATA_W])) *
                              (2*DATA_W)'($signed(weight_i[i*DATA_W +: DATA_W])));
    end
  end

  // Next accumulator value: the first beat restarts from the aligned bias.
  always_comb begin
    acc_base_s = '0;
    if (acc_first_i) begin
      acc_base_s = ACC_W'(bias_q) <<< FRAC_BITS;
    end else begin
      acc_base_s = acc_q;
    end
    acc_next_s = acc_base_s + ACC_W'(psum_q);
  end

  // Round/shift/saturate the completed window, then apply the optional ReLU.
  always_comb begin
    res_sat_s = DATA_W'(sat_round(SAT_W'(acc_next_s), FRAC_BITS, DATA_W));
    res_d     = res_sat_s;
`ifdef CONV_MAC_RELU_EN
    if (res_sat_s[DATA_W-1]) begin
      res_d = '0;
    end else begin
      res_d = res_sat_s;
    end
`endif
  end

  // P1 dot product / bias capture, P2 accumulator and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q <= '0;
      bias_q <= '0;
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      if (p1_load_i) begin
        psum_q <= psum_d;
      end
      if (p1_load_i && p1_first_i) begin
        bias_q <= bias_i;
      end
      if (acc_en_i) begin
        acc_q <= acc_next_s;
      end
      if (res_load_i) begin
        data_q <= res_d;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array: pipelined OUT_CH-lane convolution MAC with bias,
// rounding, saturation and valid/ready flow control. One beat carries an
// IN_CH pixel vector and all OUT_CH*IN_CH weights; TAPS beats form a window.
// Control (tap counter, pipeline valids, stall) lives here; the datapath is
// replicated per output channel in conv_mac_lane.
// Optional build macro CONV_MAC_RELU_EN: negative results become zero.
module conv_mac_array
  import conv_mac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IN_CH     = 3,
  parameter int OUT_CH    = 8,
  parameter int TAPS      = 9,
  parameter int FRAC_BITS = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_CH*DATA_W-1:0]        in_pixel,
  input  logic [OUT_CH*IN_CH*DATA_W-1:0] in_weight,
  input  logic [OUT_CH*DATA_W-1:0]       in_bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_CH*DATA_W-1:0]       out_data
);

  localparam int TAP_W = (clog2(TAPS) > 0) ? clog2(TAPS) : 1;

  logic [TAP_W-1:0] tap_cnt_q;
  logic [TAP_W-1:0] tap_cnt_d;
  logic             p1_valid_q;
  logic             p1_valid_d;
  logic             p1_first_q;
  logic             p1_first_d;
  logic             p1_last_q;
  logic             p1_last_d;
  logic             out_valid_q;
  logic             out_valid_d;

  logic             stall_s;
  logic             accept_s;
  logic             first_s;
  logic             last_s;
  logic             acc_en_s;
  logic             res_load_s;

  // Handshake qualifiers: a finished window cannot advance while the output is blocked.
  always_comb begin
    stall_s    = p1_valid_q && p1_last_q && out_valid_q && !out_ready;
    in_ready   = !stall_s && !clear;
    accept_s   = in_valid && in_ready;
    first_s    = (tap_cnt_q == '0);
    last_s     = (tap_cnt_q == TAP_W'(TAPS - 1));
    acc_en_s   = p1_valid_q && !stall_s && !clear;
    res_load_s = acc_en_s && p1_last_q;
  end

  // Next-state for tap counter, P1 tags and output valid; clear overrides every handshake.
  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    p1_valid_d  = p1_valid_q;
    p1_first_d  = p1_first_q;
    p1_last_d   = p1_last_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      tap_cnt_d   = '0;
      p1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept_s) begin
        tap_cnt_d  = last_s ? '0 : tap_cnt_q + TAP_W'(1);
        p1_valid_d = 1'b1;
        p1_first_d = first_s;
        p1_last_d  = last_s;
      end else if (!stall_s) begin
        p1_valid_d = 1'b0;
      end else begin
        p1_valid_d = p1_valid_q;
      end
      if (res_load_s) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt_q   <= '0;
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      p1_valid_q  <= p1_valid_d;
      p1_first_q  <= p1_first_d;
      p1_last_q   <= p1_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar o = 0; o < OUT_CH; o++) begin : g_lane
    conv_mac_lane #(
      .DATA_W   (DATA_W),
      .IN_CH    (IN_CH),
      .TAPS     (TAPS),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .p1_load_i  (accept_s),
      .p1_first_i (first_s),
      .pixel_i    (in_pixel),
      .weight_i   (in_weight[o*IN_CH*DATA_W +: IN_CH*DATA_W]),
      .bias_i     (in_bias[o*DATA_W +: DATA_W]),
      .acc_en_i   (acc_en_s),
      .acc_first_i(p1_first_q),
      .res_load_i (res_load_s),
      .data_o     (out_data[o*DATA_W +: DATA_W])
    );
  end

endmodule
